window_streamer: RTL and testbench

WINDOW_STREAMER -- requirements
Module: window_streamer

---
 rtl/window_streamer_if.sv | 31 +++
 rtl/window_streamer.sv | 198 +++++++++++++++++++
 tb/tb_window_streamer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_streamer_if.sv
// rtl/window_streamer_if.sv - image/kernel read ports and operand stream bundle
interface window_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              img_rd_en;
  logic [ADDR_W-1:0] img_addr;
  logic [DATA_W-1:0] img_rdata;
  logic              ker_rd_en;
  logic [ADDR_W-1:0] ker_addr;
  logic [DATA_W-1:0] ker_rdata;
  logic [DATA_W-1:0] pixel_out;
  logic [DATA_W-1:0] weight_out;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output img_rd_en, img_addr, ker_rd_en, ker_addr,
    input  img_rdata, ker_rdata,
    output pixel_out, weight_out, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  img_rd_en, img_addr, ker_rd_en, ker_addr,
    output img_rdata, ker_rdata,
    input  pixel_out, weight_out, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/window_streamer.sv
// rtl/window_streamer.sv - sliding-window operand streamer for one convolution pass
module window_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] kernel_size,
  input  logic [7:0] img_width,
  input  logic [7:0] img_height,
  output logic       busy,
  output logic       done,
  output logic       err,
  window_streamer_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef logic [ADDR_W-1:0] addr_t;

  state_t            state_q, state_d;
  logic [7:0]        k_q, k_d, w_q, w_d, h_q, h_d;
  logic [7:0]        ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
  logic              rd_pend_q, rd_pend_d, pend_last_q, pend_last_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d, last_q, last_d;
  logic [DATA_W-1:0] pix_q, pix_d, wgt_q, wgt_d;
  logic              skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_pix_q, skid_pix_d, skid_wgt_q, skid_wgt_d;

  logic       legal, xfer, issue, win_end, row_end, col_end, out_free;
  logic [1:0] occ;

  assign legal   = (kernel_size != 8'd0) && (kernel_size <= img_width) && (kernel_size <= img_height);
  assign xfer    = vld_q && bus.out_ready;
  // Occupancy counts the beat leaving this cycle as already gone, so a full
  // pipeline with out_ready high keeps issuing one read per cycle.
  assign occ     = {1'b0, vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q} - {1'b0, xfer};
  assign issue   = (state_q == S_RUN) && (occ < 2'd2);
  assign win_end = (kx_q == k_q - 8'd1) && (ky_q == k_q - 8'd1);
  assign row_end = (ox_q == w_q - k_q);
  assign col_end = (oy_q == h_q - k_q);
  assign out_free = !vld_q || bus.out_ready;

  assign bus.img_rd_en  = issue;
  assign bus.ker_rd_en  = issue;
  assign bus.img_addr   = (addr_t'(oy_q) + addr_t'(ky_q)) * addr_t'(w_q) + addr_t'(ox_q) + addr_t'(kx_q);
  assign bus.ker_addr   = addr_t'(ky_q) * addr_t'(k_q) + addr_t'(kx_q);
  assign bus.pixel_out  = pix_q;
  assign bus.weight_out = wgt_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_last   = last_q;
  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  // Pass sequencing: parameter capture, window/position counters, drain detection.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    w_d         = w_q;
    h_d         = h_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    err_d       = 1'b0;
    rd_pend_d   = issue;
    pend_last_d = issue && win_end;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            k_d     = kernel_size;
            w_d     = img_width;
            h_d     = img_height;
            ox_d    = 8'd0;
            oy_d    = 8'd0;
            kx_d    = 8'd0;
            ky_d    = 8'd0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          if (kx_q != k_q - 8'd1) begin
            kx_d = kx_q + 8'd1;
          end else begin
            kx_d = 8'd0;
            if (ky_q != k_q - 8'd1) begin
              ky_d = ky_q + 8'd1;
            end else begin
              ky_d = 8'd0;
              if (!row_end) begin
                ox_d = ox_q + 8'd1;
              end else begin
                ox_d = 8'd0;
                oy_d = col_end ? 8'd0 : oy_q + 8'd1;
                if (col_end) state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (!rd_pend_q && !skid_vld_q && out_free) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register plus skid entry; returning read data is never dropped.
  always_comb begin
    vld_d       = vld_q;
    last_d      = last_q;
    pix_d       = pix_q;
    wgt_d       = wgt_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_pix_d  = skid_pix_q;
    skid_wgt_d  = skid_wgt_q;
    if (out_free) begin
      if (skid_vld_q) begin
        vld_d      = 1'b1;
        last_d     = skid_last_q;
        pix_d      = skid_pix_q;
        wgt_d      = skid_wgt_q;
        skid_vld_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_last_d = pend_last_q;
          skid_pix_d  = bus.img_rdata;
          skid_wgt_d  = bus.ker_rdata;
        end
      end else if (rd_pend_q) begin
        vld_d  = 1'b1;
        last_d = pend_last_q;
        pix_d  = bus.img_rdata;
        wgt_d  = bus.ker_rdata;
      end else begin
        vld_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_vld_d  = 1'b1;
      skid_last_d = pend_last_q;
      skid_pix_d  = bus.img_rdata;
      skid_wgt_d  = bus.ker_rdata;
    end
  end

  // State registers; reset abandons any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 8'd0;
      w_q         <= 8'd0;
      h_q         <= 8'd0;
      ox_q        <= 8'd0;
      oy_q        <= 8'd0;
      kx_q        <= 8'd0;
      ky_q        <= 8'd0;
      rd_pend_q   <= 1'b0;
      pend_last_q <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      pix_q       <= '0;
      wgt_q       <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_pix_q  <= '0;
      skid_wgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      w_q         <= w_d;
      h_q         <= h_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      rd_pend_q   <= rd_pend_d;
      pend_last_q <= pend_last_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_pix_q  <= skid_pix_d;
      skid_wgt_q  <= skid_wgt_d;
    end
  end
endmodule

// File: tb/tb_window_streamer.sv
// tb/tb_window_streamer.sv - randomized self-checking bench for window_streamer
module tb_window_streamer;
  logic       clk, rst, start;
  logic [7:0] kernel_size, img_width, img_height;
  logic       busy, done, err;

  window_streamer_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  window_streamer #(.DATA_W(32), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .kernel_size(kernel_size), .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          beats, total, done_cnt, last_xfer, stall_left, rdy_mode;
  bit          mon_en;
  logic [31:0] img_xor, ker_xor;
  logic [31:0] exp_pix[$], exp_wgt[$];
  bit          exp_last[$];
  bit          prev_stall;
  logic [31:0] prev_pix, prev_wgt;
  logic        prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memories: one-cycle read latency, contents are address XOR a per-pass mask.
  always @(posedge clk) begin
    bus.img_rdata <= bus.img_rd_en ? ({16'h0, bus.img_addr} ^ img_xor) : $urandom();
    bus.ker_rdata <= bus.ker_rd_en ? ({16'h0, bus.ker_addr} ^ ker_xor) : $urandom();
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      1: bus.out_ready = ($urandom_range(3, 0) != 0);
      2: begin
        if (beats == 5 && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      default: bus.out_ready = 1'b1;
    endcase
    @(negedge clk);
    if (mon_en) begin
      if (rdy_mode == 0 && beats > 0 && beats < total) check("no_gap", bus.out_valid, 1);
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_pixel", bus.pixel_out, prev_pix);
        check("hold_weight", bus.weight_out, prev_wgt);
        check("hold_last", bus.out_last, prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (beats < total) begin
          check("pixel", bus.pixel_out, exp_pix[beats]);
          check("weight", bus.weight_out, exp_wgt[beats]);
          check("last", bus.out_last, exp_last[beats]);
        end else begin
          check("beat_overrun", beats + 1, total);
        end
        beats++;
        last_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_xfer + 1);
        check("done_beats", beats, total);
        check("busy_at_done", busy, 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.pixel_out;
      prev_wgt   = bus.weight_out;
      prev_last  = bus.out_last;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_img_rd"}, bus.img_rd_en, 0);
    check({tag, "_ker_rd"}, bus.ker_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pixel"}, bus.pixel_out, 0);
    check({tag, "_weight"}, bus.weight_out, 0);
    check({tag, "_img_addr"}, bus.img_addr, 0);
    check({tag, "_ker_addr"}, bus.ker_addr, 0);
  endtask

  task automatic begin_pass(input int k, input int w, input int h, input int mode, input logic [31:0] ix, input logic [31:0] kx_mask);
    logic [15:0] a;
    exp_pix.delete();
    exp_wgt.delete();
    exp_last.delete();
    img_xor = ix;
    ker_xor = kx_mask;
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            a = 16'((oy + ky) * w + ox + kx);
            exp_pix.push_back({16'h0, a} ^ ix);
            a = 16'(ky * k + kx);
            exp_wgt.push_back({16'h0, a} ^ kx_mask);
            exp_last.push_back(ky == k - 1 && kx == k - 1);
          end
    total = exp_pix.size();
    beats = 0;
    done_cnt = 0;
    last_xfer = -100;
    stall_left = 3;
    prev_stall = 0;
    rdy_mode = mode;
    mon_en = 1;
    kernel_size = 8'(k);
    img_width = 8'(w);
    img_height = 8'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    kernel_size = 8'($urandom());
    img_width = 8'($urandom());
    img_height = 8'($urandom());
    check("first_img_rd", bus.img_rd_en, 1);
    check("first_ker_rd", bus.ker_rd_en, 1);
    check("first_img_addr", bus.img_addr, 0);
    check("first_ker_addr", bus.ker_addr, 0);
    check("busy_after_start", busy, 1);
    tick();
    check("valid_not_yet", bus.out_valid, 0);
    tick();
    check("first_valid", bus.out_valid, 1);
  endtask

  task automatic finish_pass();
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, 1);
    check("beat_total", beats, total);
    repeat (3) tick();
    check("done_pulses", done_cnt, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_pass(input int k, input int w, input int h, input int mode, input bit restart, input logic [31:0] ix, input logic [31:0] kx_mask);
    begin_pass(k, w, h, mode, ix, kx_mask);
    if (restart) begin
      repeat ($urandom_range(3, 0)) tick();
      start = 1'b1;
      kernel_size = 8'd1;
      img_width = 8'd1;
      img_height = 8'd1;
      tick();
      start = 1'b0;
    end
    finish_pass();
  endtask

  task automatic illegal(input int k, input int w, input int h);
    mon_en = 0;
    kernel_size = 8'(k);
    img_width = 8'(w);
    img_height = 8'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_no_read", bus.img_rd_en, 0);
    repeat (4) begin
      tick();
      check("err_single", err, 0);
      check("err_busy_low", busy, 0);
      check("err_read_low", bus.img_rd_en, 0);
    end
  endtask

  initial begin
    int k, w, h, t, n;
    rst = 1'b1;
    start = 1'b0;
    kernel_size = 8'd0;
    img_width = 8'd0;
    img_height = 8'd0;
    bus.out_ready = 1'b1;
    img_xor = 32'h0;
    ker_xor = 32'h0;
    mon_en = 0;
    rdy_mode = 0;
    beats = 0;
    total = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    run_pass(2, 3, 3, 0, 0, 32'h0, 32'h0);
    run_pass(3, 3, 3, 0, 0, 32'h0, 32'h0);
    run_pass(2, 3, 3, 2, 0, $urandom(), $urandom());
    run_pass(1, 1, 1, 0, 0, $urandom(), $urandom());
    illegal(4, 3, 3);
    illegal(0, 3, 3);
    illegal(2, 5, 1);

    begin_pass(2, 3, 3, 0, 32'h0, 32'h0);
    n = 0;
    while (beats < 5 && n < 100) begin
      tick();
      n++;
    end
    check("abort_reached", beats, 5);
    rst = 1'b1;
    start = 1'b1;
    kernel_size = 8'd2;
    img_width = 8'd3;
    img_height = 8'd3;
    mon_en = 0;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    start = 1'b0;
    repeat (5) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_no_busy", busy, 0);
      check("abort_no_valid", bus.out_valid, 0);
    end
    run_pass(2, 3, 3, 0, 0, 32'h0, 32'h0);

    run_pass(3, 6, 5, 0, 1, $urandom(), $urandom());

    repeat (8) begin
      k = $urandom_range(4, 1);
      w = $urandom_range(8, k);
      h = $urandom_range(8, k);
      t = (h - k + 1) * (w - k + 1) * k * k;
      run_pass(k, w, h, $urandom_range(1, 0), (t > 20) && ($urandom_range(1, 0) == 1), $urandom(), $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
